multi_dump_sm: RTL and testbench
================================

MULTI_DUMP_SM -- requirements
Module: multi_dump_sm

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of capture channels, legal range 1..4.
REQ-002 SHALL have parameter ADDR_W, default 8: sample RAM address width.
REQ-003 SHALL have parameter GAIN_W, fixed at 3: AFE gain code width per channel.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- start_dump  in  1  one-cycle dump request.
- channel  in  2  channel to dump, sampled with start_dump.
- addr  in  ADDR_W  current RAM read pointer.
- dump_len  in  ADDR_W  sample count, sampled with start_dump; 0 means 2^ADDR_W.
- afe_gain  in  NUM_CH*GAIN_W  packed gain codes; channel 0 in the LSBs.
- spi_rdy  in  1  SPI master idle/done.
- uart_rdy  in  1  UART transmitter idle.
- abort  in  1  dump abort request (exists only under DUMP_ABORT_EN).
- start_spi  out  1  one-cycle SPI transaction start.
- spi_tx_data  out  16  SPI command word.
- flop_gain, flop_offset  out  1  capture strobes for EEPROM read-back data.
- start_uart_resp  out  1  one-cycle UART sample send.
- inc_addr  out  1  one-cycle RAM pointer advance.
- ch_sel  out  2  latched channel.
- busy  out  1  high in every state except IDLE.
- dump_done  out  1  one-cycle completion pulse.
- dump_err  out  1  one-cycle invalid-channel pulse.

Function
REQ-005 States SHALL be IDLE, RD_GAIN, RD_OFFSET, RD_JUNK, EE_WAIT, UART_SEND, INC, CHECK, DONE.
REQ-006 IDLE + start_dump with channel < NUM_CH SHALL latch ch_sel, dump_len and a sample counter in the same cycle, then go to RD_GAIN.
REQ-007 IDLE + start_dump with channel >= NUM_CH SHALL pulse dump_err for 1 cycle, stay in IDLE and leave ch_sel unchanged.
REQ-008 RD_GAIN SHALL pulse start_spi with spi_tx_data = {2'b00, ch_sel, gain[ch_sel], 9'h100}, then go to RD_OFFSET unconditionally.
REQ-009 RD_OFFSET SHALL wait for spi_rdy; on spi_rdy it SHALL pulse start_spi with {2'b00, ch_sel, gain[ch_sel], 9'h000} and go to RD_JUNK.
REQ-010 RD_JUNK SHALL wait for spi_rdy; on spi_rdy it SHALL pulse flop_gain, issue the same word as REQ-009, and go to EE_WAIT.
REQ-011 EE_WAIT SHALL wait for spi_rdy; on spi_rdy it SHALL pulse flop_offset and go to UART_SEND.
REQ-012 UART_SEND SHALL wait for uart_rdy; on uart_rdy it SHALL pulse start_uart_resp and go to INC.
REQ-013 INC SHALL pulse inc_addr, decrement the sample counter, and go to CHECK.
REQ-014 CHECK SHALL go to DONE when the counter is 0, else to UART_SEND.
REQ-015 The sample counter SHALL be ADDR_W+1 bits and load 2^ADDR_W when dump_len = 0; addr wraps modulo 2^ADDR_W, and the block does not inspect addr.
REQ-016 DONE SHALL wait for uart_rdy (last byte drained); on uart_rdy it SHALL pulse dump_done and go to IDLE.
REQ-017 start_dump outside IDLE SHALL be ignored.
REQ-018 spi_tx_data SHALL be 16'h0000 in every cycle in which start_spi is low.
REQ-019 Every strobe SHALL be high for exactly 1 cycle per event; all outputs SHALL be registered-state decodes with no combinational path from spi_rdy/uart_rdy to state.
REQ-020 Illegal state encodings SHALL return to IDLE on the next clock.

Reset
REQ-021 rst high at a posedge SHALL force IDLE, ch_sel=0, counter=0 and all strobes, busy, dump_done and dump_err to 0, including mid-dump; no dump_done is issued for a dump cut off by reset.

Configuration
REQ-022 With DUMP_ABORT_EN defined, abort high in any non-IDLE state SHALL go to DONE on the next clock, skip any further start_uart_resp and inc_addr, and complete per REQ-016; abort in IDLE is ignored.
REQ-023 Without DUMP_ABORT_EN, the abort port and its logic SHALL be absent.

Structure
REQ-024 A shared package dump_pkg SHALL hold the state_t enum, the SPI command constants (RD_GAIN 9'h100, RD_OFF 9'h000), and the CH_W=2 and GAIN_W=3 constants.
REQ-025 One sub-module, dump_gain_mux (NUM_CH-way gain selector, 0 for out-of-range), SHALL be instantiated; everything else stays in multi_dump_sm.

Verification
REQ-026 NUM_CH=3, channel=1, afe_gain ch1=3'b101, dump_len=4 -> spi words 16'h1B00, 16'h1A00, 16'h1A00, then exactly 4 start_uart_resp, 4 inc_addr, 1 dump_done.
REQ-027 ADDR_W=8, dump_len=0 -> 256 start_uart_resp pulses before dump_done.
REQ-028 NUM_CH=3, channel=3 -> dump_err 1 cycle, busy stays 0, no start_spi.
REQ-029 uart_rdy held low 20 cycles in UART_SEND -> no start_uart_resp until uart_rdy rises, then exactly one pulse.
REQ-030 rst asserted during RD_JUNK -> next cycle IDLE, all outputs 0; a new start_dump then restarts cleanly at RD_GAIN.
REQ-031 DUMP_ABORT_EN defined, abort after the 2nd sample of 8 -> 2 start_uart_resp total, then dump_done once uart_rdy is high.

Source files
------------

// File: rtl/dump_pkg.sv
// Shared types and constants for the multi-channel sample dump sequencer:
// FSM state encoding, EEPROM SPI command suffixes and field widths.
package dump_pkg;

    localparam int CH_W   = 2;
    localparam int GAIN_W = 3;

    localparam logic [8:0] CMD_RD_GAIN = 9'h100;
    localparam logic [8:0] CMD_RD_OFF  = 9'h000;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        RD_GAIN   = 4'd1,
        RD_OFFSET = 4'd2,
        RD_JUNK   = 4'd3,
        EE_WAIT   = 4'd4,
        UART_SEND = 4'd5,
        INC       = 4'd6,
        CHECK     = 4'd7,
        DONE      = 4'd8
    } state_t;

    // SPI command word: {2'b00, channel, gain code, 9-bit command}.
    function automatic logic [15:0] spi_word(input logic [CH_W-1:0]   ch,
                                             input logic [GAIN_W-1:0] gain,
                                             input logic [8:0]        cmd);
        return {2'b00, ch, gain, cmd};
    endfunction

endpackage

// File: rtl/dump_gain_mux.sv
// NUM_CH-way selector for the packed AFE gain codes; channels outside
// 0..NUM_CH-1 read as gain code 0.
module dump_gain_mux #(
    parameter int NUM_CH = 3,
    parameter int GAIN_W = 3,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH*GAIN_W-1:0] gains_i,
    input  logic [CH_W-1:0]          sel_i,
    output logic [GAIN_W-1:0]        gain_o
);

    always_comb begin
        gain_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_i == CH_W'(i)) begin
                gain_o = gains_i[i*GAIN_W +: GAIN_W];
            end
        end
    end

endmodule

// File: rtl/multi_dump_sm.sv
// Sample dump sequencer: reads gain/offset calibration from the EEPROM over SPI,
// then streams dump_len samples out of the UART. Optional abort: DUMP_ABORT_EN.
module multi_dump_sm #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 8,
    parameter int GAIN_W = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_dump,
    input  logic [dump_pkg::CH_W-1:0]    channel,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [ADDR_W-1:0]            dump_len,
    input  logic [NUM_CH*GAIN_W-1:0]     afe_gain,
    input  logic                         spi_rdy,
    input  logic                         uart_rdy,
`ifdef DUMP_ABORT_EN
    input  logic                         abort,
`endif
    output logic                         start_spi,
    output logic [15:0]                  spi_tx_data,
    output logic                         flop_gain,
    output logic                         flop_offset,
    output logic                         start_uart_resp,
    output logic                         inc_addr,
    output logic [dump_pkg::CH_W-1:0]    ch_sel,
    output logic                         busy,
    output logic                         dump_done,
    output logic                         dump_err
);

    import dump_pkg::*;

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [2:0] NUM_CH_L = 3'(NUM_CH);

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CH_W-1:0]     ch_sel_q;
    logic                start_spi_q;
    logic [15:0]         spi_tx_data_q;
    logic                flop_gain_q;
    logic                flop_offset_q;
    logic                start_uart_q;
    logic                inc_addr_q;
    logic                dump_done_q;
    logic                dump_err_q;

    logic [CNT_W-1:0]    len_d;
    logic                ch_ok_d;
    logic [GAIN_W-1:0]   gain_sel;
    logic                abort_hit;

    // The RAM pointer is owned by the reader; the sequencer only advances it.
    logic unused_addr;
    assign unused_addr = ^addr;

    dump_gain_mux #(
        .NUM_CH (NUM_CH),
        .GAIN_W (GAIN_W),
        .CH_W   (CH_W)
    ) u_gain_mux (
        .gains_i (afe_gain),
        .sel_i   (ch_sel_q),
        .gain_o  (gain_sel)
    );

    assign len_d   = (dump_len == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, dump_len};
    assign ch_ok_d = ({1'b0, channel} < NUM_CH_L);

`ifdef DUMP_ABORT_EN
    // DONE is excluded so a held abort cannot starve the final handshake.
    assign abort_hit = abort && (state_q != IDLE) && (state_q != DONE);
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        start_spi_q   <= 1'b0;
        spi_tx_data_q <= 16'h0000;
        flop_gain_q   <= 1'b0;
        flop_offset_q <= 1'b0;
        start_uart_q  <= 1'b0;
        inc_addr_q    <= 1'b0;
        dump_done_q   <= 1'b0;
        dump_err_q    <= 1'b0;
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ch_sel_q <= '0;
        end else if (abort_hit) begin
            state_q <= DONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_dump) begin
                        if (ch_ok_d) begin
                            ch_sel_q <= channel;
                            cnt_q    <= len_d;
                            state_q  <= RD_GAIN;
                        end else begin
                            dump_err_q <= 1'b1;
                        end
                    end
                end
                RD_GAIN: begin
                    start_spi_q   <= 1'b1;
                    spi_tx_data_q <= spi_word(ch_sel_q, gain_sel, CMD_RD_GAIN);
                    state_q       <= RD_OFFSET;
                end
                RD_OFFSET: begin
                    if (spi_rdy) begin
                        start_spi_q   <= 1'b1;
                        spi_tx_data_q <= spi_word(ch_sel_q, gain_sel, CMD_RD_OFF);
                        state_q       <= RD_JUNK;
                    end
                end
                // Gain data returns during the offset command; the junk
                // transfer clocks the offset data back in.
                RD_JUNK: begin
                    if (spi_rdy) begin
                        flop_gain_q   <= 1'b1;
                        start_spi_q   <= 1'b1;
                        spi_tx_data_q <= spi_word(ch_sel_q, gain_sel, CMD_RD_OFF);
                        state_q       <= EE_WAIT;
                    end
                end
                EE_WAIT: begin
                    if (spi_rdy) begin
                        flop_offset_q <= 1'b1;
                        state_q       <= UART_SEND;
                    end
                end
                UART_SEND: begin
                    if (uart_rdy) begin
                        start_uart_q <= 1'b1;
                        state_q      <= INC;
                    end
                end
                INC: begin
                    inc_addr_q <= 1'b1;
                    cnt_q      <= cnt_q - CNT_W'(1);
                    state_q    <= CHECK;
                end
                CHECK: begin
                    state_q <= (cnt_q == '0) ? DONE : UART_SEND;
                end
                DONE: begin
                    if (uart_rdy) begin
                        dump_done_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign start_spi       = start_spi_q;
    assign spi_tx_data     = spi_tx_data_q;
    assign flop_gain       = flop_gain_q;
    assign flop_offset     = flop_offset_q;
    assign start_uart_resp = start_uart_q;
    assign inc_addr        = inc_addr_q;
    assign ch_sel          = ch_sel_q;
    assign busy            = (state_q != IDLE);
    assign dump_done       = dump_done_q;
    assign dump_err        = dump_err_q;

endmodule

// File: tb/tb_multi_dump_sm.sv
// Directed bench for multi_dump_sm with simple SPI/UART ready responders.
// Define DUMP_ABORT_EN to also exercise the abort path.
module tb_multi_dump_sm;

    localparam int NUM_CH = 3;
    localparam int ADDR_W = 8;
    localparam int GAIN_W = 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start_dump;
    logic [1:0]               channel;
    logic [ADDR_W-1:0]        addr;
    logic [ADDR_W-1:0]        dump_len;
    logic [NUM_CH*GAIN_W-1:0] afe_gain;
    logic                     spi_rdy;
    logic                     uart_rdy;
`ifdef DUMP_ABORT_EN
    logic                     abort;
`endif
    logic                     start_spi;
    logic [15:0]              spi_tx_data;
    logic                     flop_gain;
    logic                     flop_offset;
    logic                     start_uart_resp;
    logic                     inc_addr;
    logic [1:0]               ch_sel;
    logic                     busy;
    logic                     dump_done;
    logic                     dump_err;

    int checks = 0;
    int failures = 0;
    int spi_n = 0, uart_n = 0, inc_n = 0, done_n = 0, err_n = 0;
    int fg_n = 0, fo_n = 0, busy_n = 0, data_viol_n = 0;
    int spi_cnt = 0, uart_cnt = 0;
    logic uart_block = 1'b0;
    logic [15:0] spi_words[$];

    multi_dump_sm #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .GAIN_W(GAIN_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .start_dump      (start_dump),
        .channel         (channel),
        .addr            (addr),
        .dump_len        (dump_len),
        .afe_gain        (afe_gain),
        .spi_rdy         (spi_rdy),
        .uart_rdy        (uart_rdy),
`ifdef DUMP_ABORT_EN
        .abort           (abort),
`endif
        .start_spi       (start_spi),
        .spi_tx_data     (spi_tx_data),
        .flop_gain       (flop_gain),
        .flop_offset     (flop_offset),
        .start_uart_resp (start_uart_resp),
        .inc_addr        (inc_addr),
        .ch_sel          (ch_sel),
        .busy            (busy),
        .dump_done       (dump_done),
        .dump_err        (dump_err)
    );

    always #5 clk = ~clk;

    // Monitor and peripheral responders, 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (start_spi) begin
                spi_n++;
                spi_words.push_back(spi_tx_data);
            end else if (spi_tx_data !== 16'h0000) begin
                data_viol_n++;
            end
            if (start_uart_resp) uart_n++;
            if (inc_addr) begin
                inc_n++;
                addr = addr + 1'b1;
            end
            if (dump_done) done_n++;
            if (dump_err) err_n++;
            if (flop_gain) fg_n++;
            if (flop_offset) fo_n++;
            if (busy) busy_n++;
            if (start_spi) spi_cnt = 3;
            else if (spi_cnt > 0) spi_cnt--;
            spi_rdy = (spi_cnt == 0);
            if (start_uart_resp) uart_cnt = 2;
            else if (uart_cnt > 0) uart_cnt--;
            uart_rdy = !uart_block && (uart_cnt == 0);
        end
    end

    task automatic clear_counts();
        spi_n = 0; uart_n = 0; inc_n = 0; done_n = 0; err_n = 0;
        fg_n = 0; fo_n = 0; busy_n = 0; data_viol_n = 0;
        spi_words.delete();
    endtask

    task automatic do_start(input logic [1:0] ch, input logic [ADDR_W-1:0] len);
        @(negedge clk);
        channel = ch;
        dump_len = len;
        start_dump = 1'b1;
        @(negedge clk);
        start_dump = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_n == 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%0b expected=0", busy); end
        checks++; if (start_spi !== 1'b0) begin failures++; $display("FAIL reset_start_spi actual=%0b expected=0", start_spi); end
        checks++; if (spi_tx_data !== 16'h0000) begin failures++; $display("FAIL reset_spi_data actual=%h expected=0000", spi_tx_data); end
        checks++; if (ch_sel !== 2'd0) begin failures++; $display("FAIL reset_ch_sel actual=%0d expected=0", ch_sel); end
        checks++; if ({dump_done, dump_err} !== 2'b00) begin failures++; $display("FAIL reset_done_err actual=%b expected=00", {dump_done, dump_err}); end
        checks++; if ({start_uart_resp, inc_addr, flop_gain, flop_offset} !== 4'b0000) begin failures++; $display("FAIL reset_strobes actual=%b expected=0000", {start_uart_resp, inc_addr, flop_gain, flop_offset}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        clear_counts();
        do_start(2'd1, 8'd4);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_start actual=%0b expected=1", busy); end
        wait_done(1000);
        checks++; if (done_n != 1) begin failures++; $display("FAIL basic_done actual=%0d expected=1", done_n); end
        checks++; if (spi_n != 3) begin failures++; $display("FAIL basic_spi_count actual=%0d expected=3", spi_n); end
        checks++; if (spi_words[0] !== 16'h1B00) begin failures++; $display("FAIL basic_word0 actual=%h expected=1B00", spi_words[0]); end
        checks++; if (spi_words[1] !== 16'h1A00) begin failures++; $display("FAIL basic_word1 actual=%h expected=1A00", spi_words[1]); end
        checks++; if (spi_words[2] !== 16'h1A00) begin failures++; $display("FAIL basic_word2 actual=%h expected=1A00", spi_words[2]); end
        checks++; if (uart_n != 4) begin failures++; $display("FAIL basic_uart actual=%0d expected=4", uart_n); end
        checks++; if (inc_n != 4) begin failures++; $display("FAIL basic_inc actual=%0d expected=4", inc_n); end
        checks++; if (fg_n != 1 || fo_n != 1) begin failures++; $display("FAIL basic_flops actual=%0d/%0d expected=1/1", fg_n, fo_n); end
        checks++; if (ch_sel !== 2'd1) begin failures++; $display("FAIL basic_ch_sel actual=%0d expected=1", ch_sel); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end actual=%0b expected=0", busy); end
        checks++; if (data_viol_n != 0) begin failures++; $display("FAIL basic_data_idle actual=%0d expected=0", data_viol_n); end
    endtask

    task automatic test_ignore_start();
        clear_counts();
        do_start(2'd0, 8'd2);
        for (int i = 0; i < 200 && fg_n == 0; i++) @(negedge clk);
        do_start(2'd2, 8'd7);
        wait_done(1000);
        checks++; if (done_n != 1) begin failures++; $display("FAIL ignore_done actual=%0d expected=1", done_n); end
        checks++; if (uart_n != 2) begin failures++; $display("FAIL ignore_uart actual=%0d expected=2", uart_n); end
        checks++; if (ch_sel !== 2'd0) begin failures++; $display("FAIL ignore_ch_sel actual=%0d expected=0", ch_sel); end
        checks++; if (spi_n != 3) begin failures++; $display("FAIL ignore_spi_count actual=%0d expected=3", spi_n); end
        checks++; if (spi_words[0] !== 16'h0500) begin failures++; $display("FAIL ignore_word0 actual=%h expected=0500", spi_words[0]); end
        checks++; if (spi_words[2] !== 16'h0400) begin failures++; $display("FAIL ignore_word2 actual=%h expected=0400", spi_words[2]); end
    endtask

    task automatic test_bad_channel();
        clear_counts();
        do_start(2'd3, 8'd5);
        repeat (6) @(negedge clk);
        checks++; if (err_n != 1) begin failures++; $display("FAIL badch_err actual=%0d expected=1", err_n); end
        checks++; if (busy_n != 0) begin failures++; $display("FAIL badch_busy actual=%0d expected=0", busy_n); end
        checks++; if (spi_n != 0) begin failures++; $display("FAIL badch_spi actual=%0d expected=0", spi_n); end
        checks++; if (ch_sel !== 2'd0) begin failures++; $display("FAIL badch_ch_sel actual=%0d expected=0", ch_sel); end
        checks++; if (done_n != 0) begin failures++; $display("FAIL badch_done actual=%0d expected=0", done_n); end
    endtask

    task automatic test_uart_stall();
        clear_counts();
        uart_block = 1'b1;
        do_start(2'd2, 8'd1);
        for (int i = 0; i < 200 && fo_n == 0; i++) @(negedge clk);
        checks++; if (fo_n != 1) begin failures++; $display("FAIL stall_reach actual=%0d expected=1", fo_n); end
        repeat (20) @(negedge clk);
        checks++; if (uart_n != 0) begin failures++; $display("FAIL stall_uart_held actual=%0d expected=0", uart_n); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL stall_busy actual=%0b expected=1", busy); end
        uart_block = 1'b0;
        wait_done(200);
        checks++; if (uart_n != 1) begin failures++; $display("FAIL stall_uart_after actual=%0d expected=1", uart_n); end
        checks++; if (done_n != 1) begin failures++; $display("FAIL stall_done actual=%0d expected=1", done_n); end
        checks++; if (spi_words[0] !== 16'h2700) begin failures++; $display("FAIL stall_word0 actual=%h expected=2700", spi_words[0]); end
        checks++; if (spi_words[1] !== 16'h2600) begin failures++; $display("FAIL stall_word1 actual=%h expected=2600", spi_words[1]); end
    endtask

    task automatic test_reset_mid();
        clear_counts();
        do_start(2'd1, 8'd3);
        for (int i = 0; i < 200 && spi_n < 2; i++) @(negedge clk);
        checks++; if (spi_n != 2) begin failures++; $display("FAIL midrst_reach actual=%0d expected=2", spi_n); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy actual=%0b expected=0", busy); end
        checks++; if ({start_spi, flop_gain, flop_offset, dump_done} !== 4'b0000) begin failures++; $display("FAIL midrst_strobes actual=%b expected=0000", {start_spi, flop_gain, flop_offset, dump_done}); end
        checks++; if (spi_tx_data !== 16'h0000) begin failures++; $display("FAIL midrst_data actual=%h expected=0000", spi_tx_data); end
        checks++; if (ch_sel !== 2'd0) begin failures++; $display("FAIL midrst_ch_sel actual=%0d expected=0", ch_sel); end
        repeat (10) @(negedge clk);
        checks++; if (done_n != 0 || fg_n != 0) begin failures++; $display("FAIL midrst_no_done actual=%0d/%0d expected=0/0", done_n, fg_n); end
        clear_counts();
        do_start(2'd1, 8'd2);
        wait_done(1000);
        checks++; if (spi_words[0] !== 16'h1B00) begin failures++; $display("FAIL midrst_restart_word actual=%h expected=1B00", spi_words[0]); end
        checks++; if (uart_n != 2 || done_n != 1) begin failures++; $display("FAIL midrst_restart actual=%0d/%0d expected=2/1", uart_n, done_n); end
    endtask

    task automatic test_len_zero();
        clear_counts();
        do_start(2'd2, 8'd0);
        wait_done(6000);
        checks++; if (uart_n != 256) begin failures++; $display("FAIL len0_uart actual=%0d expected=256", uart_n); end
        checks++; if (inc_n != 256) begin failures++; $display("FAIL len0_inc actual=%0d expected=256", inc_n); end
        checks++; if (done_n != 1) begin failures++; $display("FAIL len0_done actual=%0d expected=1", done_n); end
    endtask

`ifdef DUMP_ABORT_EN
    task automatic test_abort();
        clear_counts();
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy_n != 0 || done_n != 0) begin failures++; $display("FAIL abort_idle actual=%0d/%0d expected=0/0", busy_n, done_n); end
        do_start(2'd0, 8'd8);
        for (int i = 0; i < 500 && inc_n < 2; i++) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(200);
        checks++; if (uart_n != 2) begin failures++; $display("FAIL abort_uart actual=%0d expected=2", uart_n); end
        checks++; if (inc_n != 2) begin failures++; $display("FAIL abort_inc actual=%0d expected=2", inc_n); end
        checks++; if (done_n != 1) begin failures++; $display("FAIL abort_done actual=%0d expected=1", done_n); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy actual=%0b expected=0", busy); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        start_dump = 1'b0;
        channel = 2'd0;
        dump_len = '0;
        addr = '0;
        afe_gain = {3'b011, 3'b101, 3'b010};
        spi_rdy = 1'b1;
        uart_rdy = 1'b1;
`ifdef DUMP_ABORT_EN
        abort = 1'b0;
`endif
        test_reset();
        test_basic();
        test_ignore_start();
        test_bad_channel();
        test_uart_stall();
        test_reset_mid();
        test_len_zero();
`ifdef DUMP_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
